// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences IF/ID/EX/MEM/WB; all controls decode from (state, OpCode, Funct).
module multicycle_ctrl #(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic [5:0] Funct,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       ExtOp,
   output logic       LuiOp,
   output logic       halted,
   output logic [2:0] state
);
   localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                          S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                          OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                          OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                          OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23,
                          OP_SW = 6'h2B;

   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                          F_JR = 6'h08, F_JALR = 6'h09, F_ADD = 6'h20,
                          F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                          F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                          F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                          ALU_OR = 3'b011, ALU_SLT = 3'b100, ALU_SLTU = 3'b101,
                          ALU_FUNCT = 3'b110;

   logic [2:0] state_reg, state_next;
   logic       is_ralu, is_shift, is_jr, is_jalr;
   logic       is_lw, is_sw, is_beq, is_j, is_jal, is_ialu, is_legal;

   // Instruction classification; an unknown R-type funct counts as illegal
   always_comb begin
      is_ralu  = 1'b0;
      is_shift = 1'b0;
      is_jr    = 1'b0;
      is_jalr  = 1'b0;
      if (OpCode == OP_RTYPE) begin
         case (Funct)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
            F_XOR, F_NOR, F_SLT, F_SLTU:  is_ralu  = 1'b1;
            F_SLL, F_SRL, F_SRA:          is_shift = 1'b1;
            F_JR:                         is_jr    = 1'b1;
            F_JALR:                       is_jalr  = 1'b1;
            default: ;
         endcase
      end
      is_lw    = (OpCode == OP_LW);
      is_sw    = (OpCode == OP_SW);
      is_beq   = (OpCode == OP_BEQ);
      is_j     = (OpCode == OP_J);
      is_jal   = (OpCode == OP_JAL);
      is_ialu  = (OpCode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                 OP_ANDI, OP_ORI, OP_LUI});
      is_legal = is_ralu | is_shift | is_jr | is_jalr | is_lw | is_sw |
                 is_beq | is_j | is_jal | is_ialu;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= S_IF;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = S_IF;
      case (state_reg)
         S_IF:  state_next = S_ID;
         S_ID: begin
            if (is_j || is_jal)
               state_next = S_IF;
            else if (!is_legal)
               state_next = ILLEGAL_TRAP ? S_HALT : S_IF;
            else
               state_next = S_EX;
         end
         S_EX: begin
            if (is_lw || is_sw)
               state_next = S_MEM;
            else if (is_beq || is_jr || is_jalr)
               state_next = S_IF;
            else
               state_next = S_WB;
         end
         S_MEM: state_next = is_lw ? S_WB : S_IF;
         S_WB:  state_next = S_IF;
         S_HALT: state_next = S_HALT;
         default: state_next = S_IF;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = ALU_ADD;
      PCSource    = 2'b00;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      case (state_reg)
         S_IF: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = 1'b1;
         end
         // Branch target is computed speculatively into ALUOut here
         S_ID: begin
            ALUSrcB = 2'b11;
            ExtOp   = 1'b1;
            if (is_j || is_jal) begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
            if (is_jal) begin
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
            end
         end
         S_EX: begin
            if (is_ralu || is_shift) begin
               ALUSrcA = is_shift ? 2'b10 : 2'b01;
               ALUOp   = ALU_FUNCT;
            end else if (is_ialu) begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               ExtOp   = 1'b1;
               case (OpCode)
                  OP_ANDI:  begin ALUOp = ALU_AND; ExtOp = 1'b0; end
                  OP_ORI:   begin ALUOp = ALU_OR;  ExtOp = 1'b0; end
                  OP_SLTI:  ALUOp = ALU_SLT;
                  OP_SLTIU: ALUOp = ALU_SLTU;
                  OP_LUI:   LuiOp = 1'b1;
                  default: ;
               endcase
            end else if (is_lw || is_sw) begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               ExtOp   = 1'b1;
            end else if (is_beq) begin
               ALUSrcA     = 2'b01;
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
            end else if (is_jr || is_jalr) begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
               if (is_jalr) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b01;
                  MemtoReg = 2'b10;
               end
            end
         end
         S_MEM: begin
            IorD     = is_lw | is_sw;
            MemRead  = is_lw;
            MemWrite = is_sw;
         end
         S_WB: begin
            RegWrite = 1'b1;
            if (is_lw)
               MemtoReg = 2'b01;
            else if (is_ralu || is_shift)
               RegDst = 2'b01;
         end
         default: ;
      endcase
   end

   assign halted = (state_reg == S_HALT);
   assign state  = state_reg;

endmodule
